frame_buffer_ctrl: RTL and testbench

Frame buffer memory controller; the responder end of the frame-buffer read interface driven by the line buffer fill logic (rd_req/rd_addr in, rd_data/rd_rsp out).
Owns a single-port frame buffer RAM of FBUFF_DEPTH words, each holding TILES_PER_ROW packed 12-bit pixels.
Arbitrates that single port between display reads, which have priority, and a host write port used to update frame content.

---
 rtl/frame_buffer_ctrl_pkg.sv | 28 ++
 rtl/frame_buffer_ctrl_if.sv | 28 ++
 rtl/frame_buffer_ctrl_ram.sv | 29 ++
 rtl/frame_buffer_ctrl.sv | 156 +++++++++++++++
 tb/tb_frame_buffer_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/frame_buffer_ctrl_pkg.sv
// rtl/frame_buffer_ctrl_pkg.sv - frame buffer geometry, controller states and init pattern
package vga_fbuff_pkg;

  localparam int COLR_PXL_WIDTH   = 12;
  localparam int TILES_PER_ROW    = 5;
  localparam int FBUFF_DATA_WIDTH = COLR_PXL_WIDTH * TILES_PER_ROW;
  localparam int FBUFF_DEPTH      = 4800;
  localparam int FBUFF_ADDR_WIDTH = $clog2(FBUFF_DEPTH);

  typedef enum logic [2:0] {
    RESET,
    INIT,
    IDLE,
    RD_WAIT,
    RD_RSP,
    WR_ACK
  } fbuff_ctrl_state_t;

  // Slot p of word k carries (k+p) mod 4096, slot 0 in the low bits.
  function automatic logic [FBUFF_DATA_WIDTH-1:0] pattern_word(input int unsigned k);
    logic [FBUFF_DATA_WIDTH-1:0] w;
    w = '0;
    for (int p = 0; p < TILES_PER_ROW; p++)
      w[p*COLR_PXL_WIDTH +: COLR_PXL_WIDTH] = COLR_PXL_WIDTH'((k + 32'(p)) % 32'd4096);
    return w;
  endfunction

endpackage

// File: rtl/frame_buffer_ctrl_if.sv
// rtl/frame_buffer_ctrl_if.sv - display read port and host write port of the frame buffer
interface frame_buffer_ctrl_if
  import vga_fbuff_pkg::*;
#(
  parameter int ADDR_W = FBUFF_ADDR_WIDTH,
  parameter int DATA_W = FBUFF_DATA_WIDTH
);

  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_rsp_o;
  logic              wr_req_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_ack_o;

  modport master (
    output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
    input  rd_data_o, rd_rsp_o, wr_ack_o
  );

  modport slave (
    input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i,
    output rd_data_o, rd_rsp_o, wr_ack_o
  );

endinterface

// File: rtl/frame_buffer_ctrl_ram.sv
// rtl/frame_buffer_ctrl_ram.sv - single-port block RAM with RAM_LATENCY registered read stages
module xilinx_single_port_ram #(
  parameter int RAM_WIDTH   = 60,
  parameter int RAM_DEPTH   = 4800,
  parameter int RAM_LATENCY = 1
) (
  input  logic                         clka,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         wea,
  input  logic                         ena,
  output logic [RAM_WIDTH-1:0]         douta
);

  logic [RAM_WIDTH-1:0] r_mem  [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] r_pipe [RAM_LATENCY];

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) r_mem[addra] <= dina;
      else     r_pipe[0]    <= r_mem[addra];
    end
    for (int i = 1; i < RAM_LATENCY; i++)
      r_pipe[i] <= r_pipe[i-1];
  end

  assign douta = r_pipe[RAM_LATENCY-1];

endmodule

// File: rtl/frame_buffer_ctrl.sv
// rtl/frame_buffer_ctrl.sv - frame buffer RAM arbiter: display reads over host writes
// FBUFF_INIT_PATTERN_EN: fill the RAM with a test pattern after reset before accepting traffic.
module frame_buffer_ctrl
  import vga_fbuff_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  frame_buffer_ctrl_if.slave  fb,
  output logic                rd_overrun_o,
  output logic                init_done_o
);

  localparam int AW    = FBUFF_ADDR_WIDTH;
  localparam int DW    = FBUFF_DATA_WIDTH;
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [AW-1:0] LAST_A = AW'(FBUFF_DEPTH - 1);

  fbuff_ctrl_state_t r_state, w_next;

  logic [DW-1:0]    r_rd_data;
  logic             r_rd_oor;
  logic [CNT_W-1:0] r_lat_cnt;
  logic             r_rd_overrun;
  logic             r_init_done;

  logic             w_ram_en, w_ram_we;
  logic [AW-1:0]    w_ram_addr;
  logic [DW-1:0]    w_ram_din, w_ram_dout;
  logic             w_rd_go, w_rd_drop, w_pend_busy, w_lat_done;
  logic [AW-1:0]    w_rd_addr;

`ifdef FBUFF_INIT_PATTERN_EN
  logic             r_pend;
  logic [AW-1:0]    r_pend_addr;
  logic [AW-1:0]    r_init_addr;

  // A read latched during INIT stays owed until IDLE serves it; a new one meanwhile overruns.
  assign w_pend_busy = r_pend && (r_state == INIT || r_state == IDLE);
  assign w_rd_go     = fb.rd_req_i || r_pend;
  assign w_rd_addr   = r_pend ? r_pend_addr : fb.rd_addr_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_init_addr <= '0;
    end else begin
      if (r_state == INIT) begin
        r_init_addr <= r_init_addr + 1'b1;
        if (fb.rd_req_i && !r_pend) begin
          r_pend      <= 1'b1;
          r_pend_addr <= fb.rd_addr_i;
        end
      end else if (r_state == IDLE) begin
        r_pend <= 1'b0;
      end
    end
  end
`else
  assign w_pend_busy = 1'b0;
  assign w_rd_go     = fb.rd_req_i;
  assign w_rd_addr   = fb.rd_addr_i;
`endif

  assign w_lat_done = (r_lat_cnt == CNT_W'(RD_LATENCY - 1));
  assign w_rd_drop  = fb.rd_req_i &&
                      (r_state == RD_WAIT || r_state == RD_RSP || r_state == WR_ACK || w_pend_busy);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= RESET;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ram_en   = 1'b0;
    w_ram_we   = 1'b0;
    w_ram_addr = w_rd_addr;
    w_ram_din  = fb.wr_data_i;
    unique case (r_state)
`ifdef FBUFF_INIT_PATTERN_EN
      RESET: w_next = INIT;
      INIT: begin
        w_ram_en   = 1'b1;
        w_ram_we   = 1'b1;
        w_ram_addr = r_init_addr;
        w_ram_din  = pattern_word(32'(r_init_addr));
        if (r_init_addr == LAST_A) w_next = IDLE;
      end
`else
      RESET: w_next = IDLE;
`endif
      IDLE: begin
        if (w_rd_go) begin
          w_ram_en = (w_rd_addr <= LAST_A);
          w_next   = RD_WAIT;
        end else if (fb.wr_req_i) begin
          // Out-of-range writes keep the RAM untouched but are still acknowledged.
          w_ram_addr = fb.wr_addr_i;
          w_ram_en   = (fb.wr_addr_i <= LAST_A);
          w_ram_we   = (fb.wr_addr_i <= LAST_A);
          w_next     = WR_ACK;
        end
      end
      RD_WAIT: if (w_lat_done) w_next = RD_RSP;
      RD_RSP:  w_next = IDLE;
      WR_ACK:  w_next = IDLE;
      default: w_next = RESET;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rd_data    <= '0;
      r_rd_oor     <= 1'b0;
      r_lat_cnt    <= '0;
      r_rd_overrun <= 1'b0;
      r_init_done  <= 1'b0;
    end else begin
      if (r_state == IDLE && w_rd_go) begin
        r_rd_oor  <= (w_rd_addr > LAST_A);
        r_lat_cnt <= '0;
      end else if (r_state == RD_WAIT) begin
        r_lat_cnt <= r_lat_cnt + 1'b1;
      end
      if (r_state == RD_WAIT && w_lat_done)
        r_rd_data <= r_rd_oor ? '0 : w_ram_dout;
      if (w_next == IDLE && (r_state == RESET || r_state == INIT))
        r_init_done <= 1'b1;
      if (w_rd_drop)
        r_rd_overrun <= 1'b1;
    end
  end

  xilinx_single_port_ram #(
    .RAM_WIDTH   (DW),
    .RAM_DEPTH   (FBUFF_DEPTH),
    .RAM_LATENCY (RD_LATENCY)
  ) u_ram (
    .clka  (clk_i),
    .addra (w_ram_addr),
    .dina  (w_ram_din),
    .wea   (w_ram_we),
    .ena   (w_ram_en),
    .douta (w_ram_dout)
  );

  assign fb.rd_data_o = r_rd_data;
  assign fb.rd_rsp_o  = (r_state == RD_RSP);
  assign fb.wr_ack_o  = (r_state == WR_ACK);
  assign rd_overrun_o = r_rd_overrun;
  assign init_done_o  = r_init_done;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb/tb_frame_buffer_ctrl.sv - scoreboard bench for frame_buffer_ctrl (honours FBUFF_INIT_PATTERN_EN)
module tb_frame_buffer_ctrl;
  import vga_fbuff_pkg::*;

  localparam int RD_LAT = 1;

  typedef struct {
    logic [FBUFF_DATA_WIDTH-1:0] data;
    int                          cyc;
  } exp_t;

  localparam logic [59:0] D_A = 60'h123_456_789_ABC_DEF;
  localparam logic [59:0] D_0 = 60'hA5A_5A5_A5A_5A5_A5A;
  localparam logic [59:0] D_1 = 60'h0F0_F0F_0F0_F0F_0F1;
  localparam logic [59:0] D_2 = 60'hFED_CBA_987_654_321;
  localparam logic [59:0] D_3 = 60'h555_AAA_555_AAA_555;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  logic rd_overrun, init_done;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  logic [59:0] exp10;

  frame_buffer_ctrl_if u_if();

  frame_buffer_ctrl #(.RD_LATENCY(RD_LAT)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .fb           (u_if.slave),
    .rd_overrun_o (rd_overrun),
    .init_done_o  (init_done)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (u_if.rd_rsp_o !== 1'b0) begin
      if (sb.size() == 0) begin
        check("rd_rsp_unexpected", u_if.rd_rsp_o, 0);
      end else begin
        e = sb.pop_front();
        check("rd_data", u_if.rd_data_o, e.data);
        if (e.cyc >= 0) check("rd_rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue_read(input logic [12:0] a, input logic [59:0] d, input int lat);
    @(posedge clk_i); #1;
    u_if.rd_req_i  = 1'b1;
    u_if.rd_addr_i = a;
    sb.push_back('{d, (lat < 0) ? -1 : cyc + lat});
    @(posedge clk_i); #1;
    u_if.rd_req_i  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk_i); #1;
    end
    check("rd_drain_pending", sb.size(), 0);
  endtask

  task automatic do_write(input logic [12:0] a, input logic [59:0] d, input int lat,
                          input bit with_rd, input logic [12:0] ra, input logic [59:0] rexp);
    int t0, t_ack;
    bit seen;
    @(posedge clk_i); #1;
    u_if.wr_req_i  = 1'b1;
    u_if.wr_addr_i = a;
    u_if.wr_data_i = d;
    if (with_rd) begin
      u_if.rd_req_i  = 1'b1;
      u_if.rd_addr_i = ra;
      sb.push_back('{rexp, cyc + RD_LAT + 1});
    end
    t0    = cyc;
    t_ack = -1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (u_if.wr_ack_o === 1'b1) begin
        seen  = 1'b1;
        t_ack = cyc;
        break;
      end
      @(posedge clk_i); #1;
      u_if.rd_req_i = 1'b0;
    end
    u_if.wr_req_i = 1'b0;
    u_if.rd_req_i = 1'b0;
    check("wr_ack_seen", seen, 1);
    check("wr_ack_cycle", t_ack - t0, lat);
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_data", u_if.rd_data_o, 0);
    check("rst_rd_rsp", u_if.rd_rsp_o, 0);
    check("rst_wr_ack", u_if.wr_ack_o, 0);
    check("rst_overrun", rd_overrun, 0);
    check("rst_init_done", init_done, 0);
  endtask

  task automatic wait_init();
    for (int i = 0; i < 6000 && init_done !== 1'b1; i++) @(negedge clk_i);
    check("init_done", init_done, 1);
  endtask

  initial begin
    u_if.rd_req_i  = 1'b0;
    u_if.rd_addr_i = '0;
    u_if.wr_req_i  = 1'b0;
    u_if.wr_addr_i = '0;
    u_if.wr_data_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs();
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("init_done_first_cycle", init_done, 0);
`ifdef FBUFF_INIT_PATTERN_EN
    issue_read(13'd4799, {12'h2C3, 12'h2C2, 12'h2C1, 12'h2C0, 12'h2BF}, -1);
    wait_init();
    drain();
    exp10 = {12'd14, 12'd13, 12'd12, 12'd11, 12'd10};
`else
    @(negedge clk_i);
    check("init_done_second_cycle", init_done, 1);
    exp10 = D_A;
`endif

    do_write(13'd10, D_A, 1, 1'b0, '0, '0);
    issue_read(13'd10, D_A, RD_LAT + 1);
    drain();

    do_write(13'd0, D_0, 1, 1'b0, '0, '0);
    do_write(13'd1, D_1, RD_LAT + 3, 1'b1, 13'd0, D_0);
    drain();
    check("overrun_clear", rd_overrun, 0);
    issue_read(13'd1, D_1, RD_LAT + 1);
    drain();

    issue_read(13'd10, D_A, RD_LAT + 1);
    u_if.rd_req_i  = 1'b1;
    u_if.rd_addr_i = 13'd0;
    @(posedge clk_i); #1;
    u_if.rd_req_i  = 1'b0;
    drain();
    check("overrun_set", rd_overrun, 1);
    repeat (3) @(negedge clk_i);
    issue_read(13'd0, D_0, RD_LAT + 1);
    drain();
    check("overrun_sticky", rd_overrun, 1);

    issue_read(13'd4800, '0, RD_LAT + 1);
    drain();
    do_write(13'd4800, D_3, 1, 1'b0, '0, '0);
    issue_read(13'd0, D_0, RD_LAT + 1);
    drain();
    do_write(13'd4799, D_2, 1, 1'b0, '0, '0);
    issue_read(13'd4799, D_2, RD_LAT + 1);
    drain();

    @(posedge clk_i); #1;
    u_if.rd_req_i  = 1'b1;
    u_if.rd_addr_i = 13'd1;
    @(posedge clk_i); #1;
    u_if.rd_req_i  = 1'b0;
    rstn_i         = 1'b0;
    @(negedge clk_i);
    check_reset_outputs();
    repeat (3) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    wait_init();
    issue_read(13'd10, exp10, RD_LAT + 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
